maquina_receptor: RTL and testbench

- Snooping-side (reacting) MSI coherence controller; it is the bus-listening counterpart of the emitter machine for one cache.
- Holds the MSI state of every line of the local cache.
- Applies local state updates issued by the emitter side.
- Reacts to coherence messages arriving on the shared bus: invalidates or downgrades lines, and runs a write-back handshake with memory when a modified line is snooped.

---
 rtl/maquina_receptor.sv | 144 ++++++++++++++
 tb/tb_maquina_receptor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/maquina_receptor.sv
// Snooping-side MSI controller: holds per-line state, applies local writes, reacts to bus messages.
// Snoop takes 3 cycles (+ wbAck wait); msgPronta/atualizaPronta low outside ESPERA. Optional ESTATISTICAS_EN counters.
module maquina_receptor #(
  parameter int LARG_INDICE = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   msgValida,
  input  logic [1:0]             msgBarramento,
  input  logic [LARG_INDICE-1:0] indiceBarramento,
  output logic                   msgPronta,
  input  logic                   atualizaValida,
  input  logic [LARG_INDICE-1:0] atualizaIndice,
  input  logic [1:0]             atualizaEstado,
  output logic                   atualizaPronta,
  input  logic [LARG_INDICE-1:0] consultaIndice,
  output logic [1:0]             estadoConsulta,
  output logic                   wbReq,
  output logic [LARG_INDICE-1:0] wbIndice,
  input  logic                   wbAck,
  output logic                   abortaMemoria,
  output logic                   erroProtocolo
`ifdef ESTATISTICAS_EN
  ,
  output logic [7:0]             contWriteBack,
  output logic [7:0]             contInvalidacoes
`endif
);

  localparam int NUM_LINHAS = 2**LARG_INDICE;

  localparam logic [1:0] INVALIDAR  = 2'b00;
  localparam logic [1:0] READ_MISS  = 2'b01;
  localparam logic [1:0] WRITE_MISS = 2'b10;
  localparam logic [1:0] SEM_MSG    = 2'b11;

  localparam logic [1:0] INVALIDO      = 2'b00;
  localparam logic [1:0] MODIFICADO    = 2'b01;
  localparam logic [1:0] COMPARTILHADO = 2'b10;

  typedef enum logic [1:0] {ESPERA, ANALISA, WRITEBACK, ATUALIZA} fase_t;

  fase_t                  fase;
  logic [1:0]             estados [NUM_LINHAS];
  logic [1:0]             msg_r;
  logic [LARG_INDICE-1:0] idx_r;
  logic [1:0]             prox_r;

  logic [1:0] estado_novo;
  logic [1:0] estado_visto;
  logic [1:0] s_calc;
  logic       wb_calc;
  logic       erro_calc;

  assign estadoConsulta = estados[consultaIndice];

  always_comb begin
    estado_novo  = (atualizaEstado == 2'b11) ? INVALIDO : atualizaEstado;
    // abortaMemoria is registered, so the accept cycle must already see a same-cycle local write
    estado_visto = (atualizaValida && atualizaIndice == indiceBarramento) ?
                   estado_novo : estados[indiceBarramento];
    s_calc    = INVALIDO;
    wb_calc   = 1'b0;
    erro_calc = 1'b0;
    case (estados[idx_r])
      MODIFICADO: begin
        case (msg_r)
          READ_MISS:  begin s_calc = COMPARTILHADO; wb_calc = 1'b1; end
          WRITE_MISS: begin s_calc = INVALIDO;      wb_calc = 1'b1; end
          default:    begin s_calc = INVALIDO;      erro_calc = 1'b1; end
        endcase
      end
      COMPARTILHADO: s_calc = (msg_r == READ_MISS) ? COMPARTILHADO : INVALIDO;
      default:       s_calc = INVALIDO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINHAS; i++) estados[i] <= INVALIDO;
      fase           <= ESPERA;
      msg_r          <= INVALIDAR;
      idx_r          <= '0;
      prox_r         <= INVALIDO;
      msgPronta      <= 1'b1;
      atualizaPronta <= 1'b1;
      wbReq          <= 1'b0;
      wbIndice       <= '0;
      abortaMemoria  <= 1'b0;
      erroProtocolo  <= 1'b0;
`ifdef ESTATISTICAS_EN
      contWriteBack    <= 8'd0;
      contInvalidacoes <= 8'd0;
`endif
    end else begin
      abortaMemoria <= 1'b0;
      case (fase)
        ESPERA: begin
          if (atualizaValida) estados[atualizaIndice] <= estado_novo;
          if (msgValida && msgBarramento != SEM_MSG) begin
            msg_r          <= msgBarramento;
            idx_r          <= indiceBarramento;
            fase           <= ANALISA;
            msgPronta      <= 1'b0;
            atualizaPronta <= 1'b0;
            abortaMemoria  <= (msgBarramento == READ_MISS) && (estado_visto == MODIFICADO);
          end
        end
        ANALISA: begin
          prox_r <= s_calc;
          if (erro_calc) erroProtocolo <= 1'b1;
          if (wb_calc) begin
            fase     <= WRITEBACK;
            wbReq    <= 1'b1;
            wbIndice <= idx_r;
          end else begin
            fase <= ATUALIZA;
          end
        end
        WRITEBACK: begin
          if (wbAck) begin
            wbReq <= 1'b0;
            fase  <= ATUALIZA;
`ifdef ESTATISTICAS_EN
            if (contWriteBack != 8'hFF) contWriteBack <= contWriteBack + 8'd1;
`endif
          end
        end
        ATUALIZA: begin
          estados[idx_r] <= prox_r;
          fase           <= ESPERA;
          msgPronta      <= 1'b1;
          atualizaPronta <= 1'b1;
`ifdef ESTATISTICAS_EN
          if (estados[idx_r] != INVALIDO && prox_r == INVALIDO && contInvalidacoes != 8'hFF)
            contInvalidacoes <= contInvalidacoes + 8'd1;
`endif
        end
        default: fase <= ESPERA;
      endcase
    end
  end

endmodule

// File: tb/tb_maquina_receptor.sv
// Directed bench for maquina_receptor; checks are sampled 1 time unit after the rising edge.
module tb_maquina_receptor;

  logic       clock = 1'b0;
  logic       reset;
  logic       msgValida;
  logic [1:0] msgBarramento;
  logic [1:0] indiceBarramento;
  logic       msgPronta;
  logic       atualizaValida;
  logic [1:0] atualizaIndice;
  logic [1:0] atualizaEstado;
  logic       atualizaPronta;
  logic [1:0] consultaIndice;
  logic [1:0] estadoConsulta;
  logic       wbReq;
  logic [1:0] wbIndice;
  logic       wbAck;
  logic       abortaMemoria;
  logic       erroProtocolo;
`ifdef ESTATISTICAS_EN
  logic [7:0] contWriteBack;
  logic [7:0] contInvalidacoes;
`endif

  int n_vet  = 0;
  int n_erro = 0;
  int wb_exp = 0;
  int inv_exp = 0;

  maquina_receptor #(.LARG_INDICE(2)) dut (
    .clock(clock), .reset(reset),
    .msgValida(msgValida), .msgBarramento(msgBarramento), .indiceBarramento(indiceBarramento),
    .msgPronta(msgPronta),
    .atualizaValida(atualizaValida), .atualizaIndice(atualizaIndice), .atualizaEstado(atualizaEstado),
    .atualizaPronta(atualizaPronta),
    .consultaIndice(consultaIndice), .estadoConsulta(estadoConsulta),
    .wbReq(wbReq), .wbIndice(wbIndice), .wbAck(wbAck),
    .abortaMemoria(abortaMemoria), .erroProtocolo(erroProtocolo)
`ifdef ESTATISTICAS_EN
    , .contWriteBack(contWriteBack), .contInvalidacoes(contInvalidacoes)
`endif
  );

  always #5 clock = ~clock;

  task automatic confere(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vet++;
    if (got !== exp) begin
      n_erro++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ver_linha(input string tag, input logic [1:0] idx, input logic [1:0] exp);
    consultaIndice = idx;
    #1;
    confere(tag, {30'd0, estadoConsulta}, {30'd0, exp});
  endtask

  task automatic atualiza(input logic [1:0] idx, input logic [1:0] st);
    atualizaValida = 1'b1;
    atualizaIndice = idx;
    atualizaEstado = st;
    tick();
    atualizaValida = 1'b0;
  endtask

  // Leaves the bench in the ANALISA cycle (or still ESPERA for semMensagem)
  task automatic envia(input logic [1:0] msg, input logic [1:0] idx);
    msgValida        = 1'b1;
    msgBarramento    = msg;
    indiceBarramento = idx;
    tick();
    msgValida     = 1'b0;
    msgBarramento = 2'b11;
  endtask

  // Entered in the first WRITEBACK cycle; holds wbAck low for 'atraso' cycles, exits in ATUALIZA
  task automatic espera_wb(input string tag, input logic [1:0] idx, input int atraso);
    for (int k = 0; k < atraso; k++) begin
      confere({tag, "_wbreq"}, {31'd0, wbReq}, 32'd1);
      confere({tag, "_wbidx"}, {30'd0, wbIndice}, {30'd0, idx});
      tick();
    end
    confere({tag, "_wbreq_ack"}, {31'd0, wbReq}, 32'd1);
    wbAck = 1'b1;
    tick();
    wbAck = 1'b0;
    wb_exp++;
    confere({tag, "_wbreq_off"}, {31'd0, wbReq}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; msgValida = 1'b0; msgBarramento = 2'b11; indiceBarramento = 2'd0;
    atualizaValida = 1'b0; atualizaIndice = 2'd0; atualizaEstado = 2'd0;
    consultaIndice = 2'd0; wbAck = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    for (int i = 0; i < 4; i++) ver_linha("rst_linha", 2'(i), 2'b00);
    confere("rst_msgpronta", {31'd0, msgPronta}, 32'd1);
    confere("rst_atzpronta", {31'd0, atualizaPronta}, 32'd1);
    confere("rst_wbreq", {31'd0, wbReq}, 32'd0);
    confere("rst_wbidx", {30'd0, wbIndice}, 32'd0);
    confere("rst_abort", {31'd0, abortaMemoria}, 32'd0);
    confere("rst_erro", {31'd0, erroProtocolo}, 32'd0);

    // semMensagem is ignored
    envia(2'b11, 2'd1);
    confere("sem_msgpronta", {31'd0, msgPronta}, 32'd1);

    // Shared line, readMiss: stays shared, no WB; local writes refused while busy
    atualiza(2'd2, 2'b10);
    ver_linha("l2_comp", 2'd2, 2'b10);
    envia(2'b01, 2'd2);
    confere("rm2_msgpronta", {31'd0, msgPronta}, 32'd0);
    confere("rm2_atzpronta", {31'd0, atualizaPronta}, 32'd0);
    confere("rm2_abort", {31'd0, abortaMemoria}, 32'd0);
    atualiza(2'd3, 2'b10);
    atualizaValida = 1'b0;
    confere("rm2_wbreq", {31'd0, wbReq}, 32'd0);
    tick();
    confere("rm2_pronta_volta", {31'd0, msgPronta}, 32'd1);
    ver_linha("rm2_linha2", 2'd2, 2'b10);
    ver_linha("busy_write_ignored", 2'd3, 2'b00);

    // Local write of 11 stores invalido
    atualiza(2'd2, 2'b11);
    ver_linha("atz11_inv", 2'd2, 2'b00);

    // Modified line, readMiss: abort pulse, 5-cycle WB, ends shared
    atualiza(2'd1, 2'b01);
    envia(2'b01, 2'd1);
    confere("rm1_abort", {31'd0, abortaMemoria}, 32'd1);
    confere("rm1_wbreq_analisa", {31'd0, wbReq}, 32'd0);
    tick();
    confere("rm1_abort_pulse", {31'd0, abortaMemoria}, 32'd0);
    espera_wb("rm1", 2'd1, 4);
    ver_linha("rm1_old_in_atualiza", 2'd1, 2'b01);
    tick();
    ver_linha("rm1_linha1", 2'd1, 2'b10);
    confere("rm1_msgpronta", {31'd0, msgPronta}, 32'd1);

    // Modified line, writeMiss, ack delay 0 and 10
    for (int r = 0; r < 2; r++) begin
      atualiza(2'd3, 2'b01);
      envia(2'b10, 2'd3);
      confere("wm3_abort", {31'd0, abortaMemoria}, 32'd0);
      tick();
      espera_wb("wm3", 2'd3, (r == 0) ? 0 : 10);
      tick();
      inv_exp++;
      ver_linha("wm3_linha3", 2'd3, 2'b00);
    end

    // Same-cycle local write and writeMiss: analysis sees the new state
    atualizaValida = 1'b1; atualizaIndice = 2'd0; atualizaEstado = 2'b01;
    envia(2'b10, 2'd0);
    atualizaValida = 1'b0;
    confere("mix_atzpronta", {31'd0, atualizaPronta}, 32'd0);
    tick();
    espera_wb("mix", 2'd0, 1);
    tick();
    inv_exp++;
    ver_linha("mix_linha0", 2'd0, 2'b00);

    // invalidar on modified line: protocol error, line invalidated, error sticky
    atualiza(2'd0, 2'b01);
    envia(2'b00, 2'd0);
    tick();
    confere("inv_wbreq", {31'd0, wbReq}, 32'd0);
    confere("inv_erro", {31'd0, erroProtocolo}, 32'd1);
    tick();
    inv_exp++;
    ver_linha("inv_linha0", 2'd0, 2'b00);
    tick();
    confere("inv_erro_sticky", {31'd0, erroProtocolo}, 32'd1);

`ifdef ESTATISTICAS_EN
    confere("cnt_wb", {24'd0, contWriteBack}, 32'(wb_exp));
    confere("cnt_inv", {24'd0, contInvalidacoes}, 32'(inv_exp));
`endif

    // Reset during WRITEBACK
    atualiza(2'd1, 2'b01);
    envia(2'b01, 2'd1);
    tick();
    confere("rwb_wbreq_on", {31'd0, wbReq}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    confere("rwb_wbreq_off", {31'd0, wbReq}, 32'd0);
    confere("rwb_msgpronta", {31'd0, msgPronta}, 32'd1);
    confere("rwb_erro", {31'd0, erroProtocolo}, 32'd0);
`ifdef ESTATISTICAS_EN
    confere("rwb_cnt_wb", {24'd0, contWriteBack}, 32'd0);
    confere("rwb_cnt_inv", {24'd0, contInvalidacoes}, 32'd0);
`endif
    for (int i = 0; i < 4; i++) ver_linha("rwb_linha", 2'(i), 2'b00);
    envia(2'b01, 2'd2);
    confere("rwb_accept", {31'd0, msgPronta}, 32'd0);
    tick(); tick();
    confere("rwb_pronta_volta", {31'd0, msgPronta}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vet, n_erro);
    $finish;
  end

endmodule
